// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC select enum for the PC unit
package pc_pkg;

  localparam int                DEFAULT_WIDTH        = 32;
  localparam int                DEFAULT_INC          = 4;
  localparam logic [31:0]       DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HOLD     = 2'd2,
    SEL_RAS      = 2'd3
  } next_pc_sel_t;

endpackage

// File: rtl/pc_if.sv
// rtl/pc_if.sv - fetch-stage control/status bundle between pipeline and PC unit
interface pc_if
  import pc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             Stall;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectTarget;
  logic             Call;
  logic             Return;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusInc;
  logic             Misaligned;
  logic             RasEmpty;
  logic             RasFull;

  // Pipeline side: drives hazard/redirect/call info, observes the fetch address.
  modport master (
    output Stall, Redirect, RedirectTarget, Call, Return,
    input  PCResult, PCPlusInc, Misaligned, RasEmpty, RasFull
  );

  // PC unit side.
  modport slave (
    input  Stall, Redirect, RedirectTarget, Call, Return,
    output PCResult, PCPlusInc, Misaligned, RasEmpty, RasFull
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with saturating count
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] PushData,
  output logic [WIDTH-1:0] Top,
  output logic             Empty,
  output logic             Full
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             pop_ok;

  assign Empty = (cnt_q == '0);
  assign Full  = (cnt_q == DEPTH_C);
  assign Top   = mem_q[ptr_q];

  // Pointer/count update; a push into a full stack wraps over the oldest entry.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    pop_ok = Pop && !Empty;
    if (Push && pop_ok) begin
      // Call and return together: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (Push) begin
      ptr_d  = ptr_q + PW'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      if (!Full) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop_ok) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and count registers; only the count matters after reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= PushData;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC register with stall/redirect and optional RAS (PC_RAS_EN)
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int               INC          = DEFAULT_INC,
  parameter int               RAS_DEPTH    = 4
) (
  input logic   Clk,
  input logic   Reset,
  pc_if.slave   bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_seq;
  next_pc_sel_t     sel;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  assign pc_seq = pc_q + INC_W;

`ifdef PC_RAS_EN
  logic ras_push;
  logic ras_pop;

  // Stack only moves when the fetch stage actually advances.
  assign ras_push = bus.Call   && !bus.Redirect && !bus.Stall;
  assign ras_pop  = bus.Return && !bus.Redirect && !bus.Stall;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk      (Clk),
    .Reset    (Reset),
    .Push     (ras_push),
    .Pop      (ras_pop),
    .PushData (pc_seq),
    .Top      (ras_top),
    .Empty    (ras_empty),
    .Full     (ras_full)
  );
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = bus.Call ^ bus.Return;
  assign ras_top   = pc_seq;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  // Next-PC priority: redirect beats stall beats predicted return beats sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (bus.Redirect) begin
      sel = SEL_REDIRECT;
    end else if (bus.Stall) begin
      sel = SEL_HOLD;
    end
`ifdef PC_RAS_EN
    else if (bus.Return && !ras_empty) begin
      sel = SEL_RAS;
    end
`endif
    pc_d = pc_seq;
    unique case (sel)
      SEL_REDIRECT: pc_d = bus.RedirectTarget;
      SEL_HOLD:     pc_d = pc_q;
      SEL_RAS:      pc_d = ras_top;
      default:      pc_d = pc_seq;
    endcase
  end

  // Fetch address register, forced to the reset vector asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.PCPlusInc  = pc_seq;
  assign bus.Misaligned = |pc_q[1:0];
  assign bus.RasEmpty   = ras_empty;
  assign bus.RasFull    = ras_full;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined datapath, replacing the plain PC register at the head of the fetch stage. It holds the fetch address, advances it by a fixed increment each cycle, and honours pipeline stalls and branch/jump redirects from later stages. An optional return-address stack predicts `jr $ra` targets at fetch. All state is clocked on `Clk` with an asynchronous reset that forces a configurable reset vector.

## Interface
Parameters:
- `WIDTH`, 32: width of the address and data path.
- `RESET_VECTOR`, 32'h00000000: value of `PCResult` during and after reset.
- `INC`, 4: sequential increment, in bytes.
- `RAS_DEPTH`, 4: number of return-address stack entries. Must be a power of two and at least 2.

Ports:
- `Clk`, in, 1: clock, rising-edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Stall`, in, 1: hold the PC (load-use hazard).
- `Redirect`, in, 1: a resolved branch or jump is taken.
- `RedirectTarget`, in, WIDTH: address to load when `Redirect` is high.
- `Call`, in, 1: the fetched instruction is `jal`/`jalr`; push `PCResult+INC`.
- `Return`, in, 1: the fetched instruction is `jr $ra`; pop the predicted target.
- `PCResult`, out, WIDTH: current fetch address (registered).
- `PCPlusInc`, out, WIDTH: `PCResult+INC` (combinational).
- `Misaligned`, out, 1: `|PCResult[1:0]` (combinational).
- `RasEmpty`, out, 1: stack count is 0.
- `RasFull`, out, 1: stack count equals `RAS_DEPTH`.

## Operation
Next-PC priority is evaluated once per cycle:
1. `Reset`: `PCResult` takes `RESET_VECTOR` and the stack count goes to 0. This is asynchronous.
2. `Redirect`: `PCResult` takes `RedirectTarget`. `Call` and `Return` are ignored, and the stack is unchanged.
3. `Stall`: `PCResult` holds, and the stack is unchanged.
4. `Return` with the stack non-empty: `PCResult` takes the top entry, and the entry is popped.
5. Otherwise: `PCResult` takes `PCResult+INC`.

Call handling:
- `Call` is acted on only when `Redirect=0` and `Stall=0`; it pushes `PCResult+INC`.
- `Call` does not change `PCResult`; the jump target arrives later via `Redirect`.

Arithmetic:
- All addition is modulo 2^WIDTH. The PC wraps from `2^WIDTH-INC` to 0 with no flag.

Return-address stack:
- Organised as a circular buffer with a top pointer and a saturating count.
- Push when full: overwrites the oldest entry. The count stays at `RAS_DEPTH` and the pointer advances.
- Pop when empty: no pop occurs, and the PC takes the sequential path (rule 5).
- `Call` and `Return` in the same cycle, stack non-empty: PC takes the current top, and the top entry is replaced by `PCResult+INC`. The count is unchanged.
- `Call` and `Return` in the same cycle, stack empty: a plain push, and the PC increments.

Misaligned targets:
- A misaligned `RedirectTarget` is loaded as-is; `Misaligned` reports it.

## Timing
- Reset: the outputs take these values as soon as `Reset` goes high, without waiting for a clock edge.
  - `PCResult = RESET_VECTOR`
  - `RasEmpty = 1`, `RasFull = 0`
  - `Misaligned = |RESET_VECTOR[1:0]`
- First edge after reset release: if `Reset` deasserts before a rising edge, that edge loads `RESET_VECTOR+INC`, assuming no other control input is active.
- Latency: one cycle. Inputs sampled on rising edge N appear on `PCResult` after edge N.
- Outputs: `PCPlusInc`, `Misaligned`, `RasEmpty` and `RasFull` follow the registered state with zero latency.
- Reset mid-operation: aborts everything, including a pending push or pop. Stack contents become don't-care; only the count is cleared.

## Configuration
- `PC_RAS_EN` defined: the return-address stack is compiled in and behaves as described above.
- `PC_RAS_EN` undefined:
  - No stack storage is built, and `Call`/`Return` are ignored.
  - Priority reduces to Reset > Redirect > Stall > increment.
  - `RasEmpty` is tied to 1 and `RasFull` is tied to 0.

## Structure
- Shared package `pc_pkg` holds:
  - the default `WIDTH`, `INC` and `RESET_VECTOR` constants;
  - the `next_pc_sel_t` enum: `SEL_SEQ`, `SEL_REDIRECT`, `SEL_HOLD`, `SEL_RAS`.
- The stack is one natural sub-module, `pc_ras`, with ports:
  - `Clk`, `Reset`, `Push`, `Pop`, `PushData`, `Top`, `Empty`, `Full`.
- `pc_ras` is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset: assert `Reset` mid-cycle with `RESET_VECTOR=32'h00400000`. `PCResult` reads 0x00400000 immediately. After release, three free-running edges give 0x00400004, 0x00400008, 0x0040000C.
- Stall/redirect priority: at PC=0x10, assert `Stall` and `Redirect` with target 0x80 together. Next PC is 0x80. With `Stall` alone for 2 cycles, PC holds at 0x80.
- Call/return: at 0x20 assert `Call`, then `Redirect` to 0x100, then at 0x104 assert `Return`. Next PC is 0x24, and `RasEmpty` returns to 1.
- Overflow: push 5 times with `RAS_DEPTH=4` (0x4, 0x8, 0xC, 0x10, 0x14), then pop 5 times. Pops return 0x14, 0x10, 0xC, 0x8. The 5th pop increments the PC normally.
- Simultaneous call and return: stack holds 0x40 and PC=0x200. Assert `Call` and `Return` together. PC becomes 0x40, the top becomes 0x204, and the count is unchanged.
- Wrap and misalignment:
  - PC=0xFFFFFFFC, free-running edge: PC becomes 0x00000000.
  - Redirect to 0x102: `Misaligned=1` on the next cycle.
